// File: rtl/led_frame_scanner_pkg.sv
// Shared definitions for the LED frame scanner: register map, STATUS layout
// and the one-hot fetch FSM encoding.
package led_frame_scanner_pkg;

  localparam logic [15:0] FRAME_MEMORY_START = 16'h1000;

  localparam logic [1:0] REG_ADDR_L = 2'd0;
  localparam logic [1:0] REG_ADDR_H = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_TMO     = 1;
  localparam int STAT_CNT_LSB = 2;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_LATCH = 6'b000010,
    S_REQ   = 6'b000100,
    S_WAIT  = 6'b001000,
    S_EMIT  = 6'b010000,
    S_DONE  = 6'b100000
  } state_e;

endpackage

// File: rtl/led_scanner_regs.sv
// Slave register window: frame pointer staging/commit, CTRL enable and STATUS
// (busy, sticky timeout, frame counter), with single-cycle ack generation.
module led_scanner_regs
  import led_frame_scanner_pkg::*;
#(
  parameter logic [15:0] RESET_FRAME_ADDR = FRAME_MEMORY_START + 16'd128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  s_adr_i,
  input  logic [7:0]  s_dat_i,
  output logic [7:0]  s_dat_o,
  input  logic        s_we_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  input  logic        i_busy,
  input  logic        i_timeout,
  input  logic        i_frame_done,
  output logic [15:0] o_frame_base,
  output logic        o_enable
);

  logic        r_ack;
  logic [7:0]  r_dat;
  logic [7:0]  r_staged_lo;
  logic [15:0] r_frame_base;
  logic        r_enable;
  logic        r_timeout;
  logic [5:0]  r_frame_cnt;
  logic        w_req;
  logic        w_wr;
  logic [7:0]  w_rd;

  // The ack register itself gates the next request, so strobes ack every other cycle.
  assign w_req = s_stb_i & s_cyc_i & ~r_ack;
  assign w_wr  = w_req & s_we_i;

  always_comb begin
    w_rd = '0;
    case (s_adr_i)
      REG_ADDR_L: w_rd = r_frame_base[7:0];
      REG_ADDR_H: w_rd = r_frame_base[15:8];
      REG_CTRL:   w_rd = {7'd0, r_enable};
      REG_STATUS: w_rd = {r_frame_cnt, r_timeout, i_busy};
      default:    w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_staged_lo  <= '0;
      r_frame_base <= RESET_FRAME_ADDR;
      r_enable     <= 1'b1;
      r_timeout    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rd : 8'h00;
      if (w_wr && s_adr_i == REG_ADDR_L) r_staged_lo <= s_dat_i;
      if (w_wr && s_adr_i == REG_ADDR_H) r_frame_base <= {s_dat_i, r_staged_lo};
      if (w_wr && s_adr_i == REG_CTRL) r_enable <= s_dat_i[0];
      // A timeout in the same cycle as the clear wins so no event is lost.
      if (i_timeout) r_timeout <= 1'b1;
      else if (w_wr && s_adr_i == REG_STATUS && s_dat_i[STAT_TMO]) r_timeout <= 1'b0;
      if (i_frame_done) r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

  assign s_ack_o      = r_ack;
  assign s_dat_o      = r_dat;
  assign o_frame_base = r_frame_base;
  assign o_enable     = r_enable;

endmodule

// File: rtl/led_frame_scanner.sv
// Bursts one frame of pixels out of frame memory over a Wishbone master and
// streams them to the LED row driver, pulsing frame_complete per frame.
module led_frame_scanner
  import led_frame_scanner_pkg::*;
#(
  parameter int          ADDRESS_WIDTH    = 16,
  parameter int          DATA_WIDTH       = 8,
  parameter int          COLS             = 18,
  parameter int          ROWS             = 7,
  parameter int          PIXEL_BYTES      = 2,
  parameter int          MAX_WAIT         = 8,
  parameter logic [15:0] RESET_FRAME_ADDR = FRAME_MEMORY_START + 16'd128
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               s_adr_i,
  input  logic [7:0]               s_dat_i,
  output logic [7:0]               s_dat_o,
  input  logic                     s_we_i,
  input  logic                     s_stb_i,
  input  logic                     s_cyc_i,
  output logic                     s_ack_o,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic                     stb_o,
  output logic                     cyc_o,
  output logic                     we_o,
  output logic [2:0]               cti_o,
  input  logic                     ack_i,
  input  logic                     mem_busy,
  output logic [15:0]              pix_data,
  output logic [2:0]               pix_row,
  output logic [4:0]               pix_col,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     frame_complete
);

  localparam int BW = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e                   r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_cur_ptr;
  logic [PIXEL_BYTES*8-1:0] r_pix;
  logic [BW-1:0]            r_byte_idx;
  logic [WW-1:0]            r_wait;
  logic [2:0]               r_row;
  logic [4:0]               r_col;
  logic [15:0]              w_frame_base;
  logic                     w_enable;
  logic                     w_timeout;
  logic                     w_byte_done;
  logic                     w_last_byte;
  logic                     w_last_col;
  logic                     w_last_pix;

  led_scanner_regs #(.RESET_FRAME_ADDR(RESET_FRAME_ADDR)) u_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s_adr_i      (s_adr_i),
    .s_dat_i      (s_dat_i),
    .s_dat_o      (s_dat_o),
    .s_we_i       (s_we_i),
    .s_stb_i      (s_stb_i),
    .s_cyc_i      (s_cyc_i),
    .s_ack_o      (s_ack_o),
    .i_busy       (r_state != S_IDLE),
    .i_timeout    (w_timeout),
    .i_frame_done (r_state == S_DONE),
    .o_frame_base (w_frame_base),
    .o_enable     (w_enable)
  );

  // Timeout fires on the MAX_WAIT-th WAIT cycle; a late ack on that cycle still wins.
  assign w_timeout   = (r_state == S_WAIT) & ~ack_i & (r_wait == WW'(MAX_WAIT - 1));
  assign w_byte_done = (r_state == S_WAIT) & (ack_i | w_timeout);
  assign w_last_byte = (r_byte_idx == BW'(PIXEL_BYTES - 1));
  assign w_last_col  = (r_col == 5'(COLS - 1));
  assign w_last_pix  = w_last_col & (r_row == 3'(ROWS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_enable && !mem_busy) w_next = S_LATCH;
      S_LATCH: w_next = S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (w_byte_done) w_next = w_last_byte ? S_EMIT : S_REQ;
      S_EMIT:  if (pix_ready) w_next = w_last_pix ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur_ptr  <= '0;
      r_pix      <= '0;
      r_byte_idx <= '0;
      r_wait     <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      case (r_state)
        // The frame pointer is shadowed here only, so commits never tear a frame.
        S_LATCH: begin
          r_cur_ptr  <= ADDRESS_WIDTH'(w_frame_base);
          r_byte_idx <= '0;
          r_row      <= '0;
          r_col      <= '0;
        end
        S_REQ: r_wait <= '0;
        S_WAIT: begin
          if (w_byte_done) begin
            r_pix[r_byte_idx*8 +: 8] <= ack_i ? dat_i[7:0] : 8'h00;
            r_cur_ptr  <= r_cur_ptr + 1'b1;
            r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_EMIT: begin
          if (pix_ready) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and pixel strobes decode straight from the state so reset drops them at once.
  assign cyc_o          = (r_state == S_REQ) | (r_state == S_WAIT);
  assign stb_o          = cyc_o;
  assign adr_o          = r_cur_ptr;
  assign we_o           = 1'b0;
  assign cti_o          = 3'b000;
  assign pix_valid      = (r_state == S_EMIT);
  assign pix_data       = 16'(r_pix);
  assign pix_row        = r_row;
  assign pix_col        = r_col;
  assign frame_complete = (r_state == S_DONE);

endmodule

// File: tb/tb_led_frame_scanner.sv
// Directed bench for led_frame_scanner: register-access vector table plus
// hand sequences for fetch, stall, timeout, pointer shadowing and reset.
module tb_led_frame_scanner;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  s_adr_i = '0;
  logic [7:0]  s_dat_i = '0;
  logic [7:0]  s_dat_o;
  logic        s_we_i = 1'b0;
  logic        s_stb_i = 1'b0;
  logic        s_cyc_i = 1'b0;
  logic        s_ack_o;
  logic [15:0] adr_o;
  logic [7:0]  dat_i = '0;
  logic        stb_o, cyc_o, we_o;
  logic [2:0]  cti_o;
  logic        ack_i = 1'b0;
  logic        mem_busy = 1'b1;
  logic [15:0] pix_data;
  logic [2:0]  pix_row;
  logic [4:0]  pix_col;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        frame_complete;

  int nchk = 0;
  int nerr = 0;

  logic        noack_en = 1'b0;
  logic [15:0] noack_adr = '0;

  int          pcnt = 0;
  int          acnt = 0;
  logic [15:0] px_d [0:127];
  logic [2:0]  px_r [0:127];
  logic [4:0]  px_c [0:127];

  led_frame_scanner dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
    .adr_o(adr_o), .dat_i(dat_i), .stb_o(stb_o), .cyc_o(cyc_o), .we_o(we_o),
    .cti_o(cti_o), .ack_i(ack_i), .mem_busy(mem_busy),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_complete(frame_complete)
  );

  always #5 clk_i = ~clk_i;

  // Frame memory: byte at address A reads as A[7:0], registered one-cycle ack.
  always @(posedge clk_i) begin
    ack_i <= cyc_o && stb_o && !ack_i && !(noack_en && adr_o == noack_adr);
    dat_i <= adr_o[7:0];
  end

  always @(posedge clk_i) begin
    if (frame_complete) begin
      pcnt <= 0;
      acnt <= 0;
    end else begin
      if (pix_valid && pix_ready && pcnt < 128) begin
        px_d[pcnt] <= pix_data;
        px_r[pcnt] <= pix_row;
        px_c[pcnt] <= pix_col;
        pcnt <= pcnt + 1;
      end
      if (ack_i && cyc_o) acnt <= acnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic reg_acc(input logic we, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    int n;
    @(negedge clk_i);
    s_adr_i = a; s_dat_i = d; s_we_i = we; s_stb_i = 1'b1; s_cyc_i = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!s_ack_o && n < 10);
    if (!s_ack_o) chk("slave_ack_timeout", 32'd0, 32'd1);
    q = s_dat_o;
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
  endtask

  task automatic wait_cyc(input string nm);
    int n = 0;
    while (!cyc_o && n < 200) begin @(negedge clk_i); n++; end
    chk(nm, {31'd0, cyc_o}, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!frame_complete && n < 3000) begin @(negedge clk_i); n++; end
    chk(nm, {31'd0, frame_complete}, 32'd1);
  endtask

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [0:14];

  initial begin
    logic [7:0] q;
    int bad;
    logic [15:0] held_d;

    vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h80};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h10};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h01};
    vecs[3]  = '{1'b0, 2'd3, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 2'd2, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 2'd2, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 2'd2, 8'hFE, 8'h00};
    vecs[7]  = '{1'b0, 2'd2, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 2'd2, 8'hFF, 8'h00};
    vecs[9]  = '{1'b0, 2'd2, 8'h00, 8'h01};
    vecs[10] = '{1'b1, 2'd0, 8'h33, 8'h00};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 8'h80};
    vecs[12] = '{1'b0, 2'd1, 8'h00, 8'h10};
    vecs[13] = '{1'b1, 2'd3, 8'hFF, 8'h00};
    vecs[14] = '{1'b0, 2'd3, 8'h00, 8'h00};

    #12;
    chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, stb_o}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_frame_complete", {31'd0, frame_complete}, 32'd0);
    chk("rst_s_ack", {31'd0, s_ack_o}, 32'd0);
    chk("rst_adr", {16'd0, adr_o}, 32'd0);
    chk("rst_cti_we", {28'd0, cti_o, we_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 15; i++) begin
      reg_acc(vecs[i].we, vecs[i].adr, vecs[i].dat, q);
      if (!vecs[i].we) chk($sformatf("reg_vec[%0d]", i), {24'd0, q}, {24'd0, vecs[i].exp});
    end

    // Enabled but memory busy: no fetch may start.
    bad = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_i); if (cyc_o) bad++; end
    chk("mem_busy_blocks", bad, 0);
    mem_busy = 1'b0;

    // Frame 1: pattern fetch, stall on pixel 5, enable cleared mid-frame.
    wait_cyc("f1_start");
    chk("f1_first_adr", {16'd0, adr_o}, 32'h1080);
    bad = 0;
    while (!(pix_valid && pix_row == 3'd0 && pix_col == 5'd4) && bad < 100) begin
      @(negedge clk_i); bad++;
    end
    @(negedge clk_i);
    pix_ready = 1'b0;
    bad = 0;
    while (!pix_valid && bad < 40) begin @(negedge clk_i); bad++; end
    chk("stall_col", {27'd0, pix_col}, 32'd5);
    chk("stall_data", {16'd0, pix_data}, 32'h8B8A);
    held_d = pix_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!pix_valid || pix_data != held_d || pix_col != 5'd5 || cyc_o) bad++;
    end
    chk("stall_hold", bad, 0);
    pix_ready = 1'b1;
    reg_acc(1'b1, 2'd2, 8'h00, q);
    wait_done("f1_done");
    chk("f1_pix_count", pcnt, 126);
    chk("f1_master_reads", acnt, 252);
    chk("f1_pix0", {px_r[0], px_c[0], px_d[0]}, {3'd0, 5'd0, 16'h8180});
    chk("f1_pix1", {px_r[1], px_c[1], px_d[1]}, {3'd0, 5'd1, 16'h8382});
    chk("f1_pix18", {px_r[18], px_c[18], px_d[18]}, {3'd1, 5'd0, 16'hA5A4});
    chk("f1_pix125", {px_r[125], px_c[125], px_d[125]}, {3'd6, 5'd17, 16'h7B7A});
    @(negedge clk_i);
    chk("f1_single_pulse", {31'd0, frame_complete}, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk_i); if (cyc_o) bad++; end
    chk("disabled_idle", bad, 0);
    reg_acc(1'b0, 2'd3, 8'h00, q);
    chk("f1_status", {24'd0, q}, 32'h04);

    // Frame 2: one unacked byte, and pointer committed mid-frame.
    noack_en = 1'b1;
    noack_adr = 16'h1085;
    reg_acc(1'b1, 2'd2, 8'h01, q);
    wait_cyc("f2_start");
    chk("f2_first_adr", {16'd0, adr_o}, 32'h1080);
    reg_acc(1'b1, 2'd0, 8'h40, q);
    reg_acc(1'b0, 2'd0, 8'h00, q);
    chk("addr_l_staged_only", {24'd0, q}, 32'h80);
    reg_acc(1'b1, 2'd1, 8'h24, q);
    reg_acc(1'b0, 2'd1, 8'h00, q);
    chk("addr_h_commit", {24'd0, q}, 32'h24);
    reg_acc(1'b0, 2'd0, 8'h00, q);
    chk("addr_l_commit", {24'd0, q}, 32'h40);
    wait_done("f2_done");
    chk("f2_pix_count", pcnt, 126);
    chk("f2_master_reads", acnt, 251);
    chk("f2_timeout_byte", {16'd0, px_d[2]}, 32'h0084);
    chk("f2_no_tear_first", {16'd0, px_d[0]}, 32'h8180);
    chk("f2_no_tear_last", {16'd0, px_d[125]}, 32'h7B7A);
    noack_en = 1'b0;

    // Frame 3 picks up the committed pointer.
    wait_cyc("f3_start");
    chk("f3_first_adr", {16'd0, adr_o}, 32'h2440);
    reg_acc(1'b1, 2'd2, 8'h00, q);
    wait_done("f3_done");
    chk("f3_pix0", {16'd0, px_d[0]}, 32'h4140);
    chk("f3_pix125", {px_r[125], px_c[125], px_d[125]}, {3'd6, 5'd17, 16'h3B3A});
    repeat (3) @(negedge clk_i);
    reg_acc(1'b0, 2'd3, 8'h00, q);
    chk("status_timeout_set", {24'd0, q}, 32'h0E);
    reg_acc(1'b1, 2'd3, 8'h02, q);
    reg_acc(1'b0, 2'd3, 8'h00, q);
    chk("status_timeout_clr", {24'd0, q}, 32'h0C);

    // Reset asserted while a master read is pending.
    noack_en = 1'b1;
    noack_adr = 16'h2441;
    reg_acc(1'b1, 2'd2, 8'h01, q);
    bad = 0;
    while (!(cyc_o && adr_o == 16'h2441) && bad < 100) begin @(negedge clk_i); bad++; end
    repeat (2) @(negedge clk_i);
    chk("pre_rst_in_wait", {31'd0, cyc_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    chk("async_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    noack_en = 1'b0;
    wait_cyc("post_rst_start");
    chk("post_rst_adr", {16'd0, adr_o}, 32'h1080);
    reg_acc(1'b0, 2'd3, 8'h00, q);
    chk("post_rst_status", {24'd0, q}, 32'h01);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
